if_fetch_unit: RTL and testbench

Instruction fetch unit that writes the IF/ID pipeline register. It owns the PC, issues one outstanding request at a time to instruction memory over a request/grant/response handshake, and presents a fetched instruction plus its PC to IF/ID. It honours the hazard unit's `pc_write` stall and EX-stage branch/jump redirects. Whenever no valid instruction is available, it drives a canonical NOP so IF/ID captures a bubble.

---
 rtl/if_pkg.sv | 14 +
 rtl/if_fetch_unit_if.sv | 27 ++
 rtl/ifu_perf_counters.sv | 22 ++
 rtl/if_fetch_unit.sv | 107 ++++++++++
 tb/tb_if_fetch_unit.sv | 325 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/if_pkg.sv
// Shared definitions for the instruction fetch unit: canonical NOP,
// fetch FSM states and the default reset PC.
package if_pkg;

  localparam logic [31:0] NOP_INSN         = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    REQ   = 2'd0,
    WAIT  = 2'd1,
    VALID = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/grant/response bus between the fetch unit
// (master) and instruction memory (slave).
interface if_fetch_unit_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );

endinterface

// File: rtl/ifu_perf_counters.sv
// Fetch performance counters: consumed instructions and pc_write stall cycles.
// Both clear on rst and wrap silently at 2^32.
module ifu_perf_counters (
  input  logic        clk,
  input  logic        rst,
  input  logic        consume,
  input  logic        stall,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall
);

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched <= 32'd0;
      perf_stall   <= 32'd0;
    end else begin
      if (consume) perf_fetched <= perf_fetched + 32'd1;
      if (stall)   perf_stall   <= perf_stall + 32'd1;
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch unit feeding IF/ID: owns the PC, keeps one imem request
// in flight, honours stalls and redirects. Optional IFU_PERF_CNT_EN adds counters.
module if_fetch_unit
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pc_write,
  input  logic                   redirect,
  input  logic [31:0]            redirect_pc,
  if_fetch_unit_if.master        imem,
  output logic [31:0]            instruction,
  output logic [31:0]            pc_out,
  output logic                   fetch_valid
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0]            perf_fetched,
  output logic [31:0]            perf_stall
`endif
);

  fetch_state_t state;
  logic [31:0]  pc;
  logic [31:0]  ibuf;
  logic         kill;
  logic [31:0]  pc_seq;
  logic         consuming;

  assign pc_seq    = pc + 32'd4;
  assign consuming = (state == VALID) && pc_write;

  // A consumed instruction launches the next fetch in the same cycle, so the
  // bus already carries the incremented PC before the register catches up.
  assign imem.imem_req  = !rst && !redirect && ((state == REQ) || consuming);
  assign imem.imem_addr = consuming ? pc_seq : pc;

  assign fetch_valid = !rst && (state == VALID);
  assign instruction = fetch_valid ? ibuf : NOP_INSN;
  assign pc_out      = pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= REQ;
      pc    <= RESET_PC;
      ibuf  <= 32'd0;
      kill  <= 1'b0;
    end else begin
      case (state)
        REQ: begin
          if (redirect) begin
            pc <= redirect_pc;
          end else if (imem.imem_gnt) begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (imem.imem_rvalid) begin
            if (kill || redirect) begin
              kill  <= 1'b0;
              state <= REQ;
              if (redirect) pc <= redirect_pc;
            end else begin
              ibuf  <= imem.imem_rdata;
              state <= VALID;
            end
          end else if (redirect) begin
            // The in-flight response belongs to the old path; drop it on arrival.
            pc   <= redirect_pc;
            kill <= 1'b1;
          end
        end
        VALID: begin
          if (redirect) begin
            pc    <= redirect_pc;
            state <= REQ;
          end else if (pc_write) begin
            pc    <= pc_seq;
            state <= imem.imem_gnt ? WAIT : REQ;
          end
        end
        default: state <= REQ;
      endcase
    end
  end

`ifdef IFU_PERF_CNT_EN
  logic perf_consume;
  logic perf_stall_cycle;

  assign perf_consume     = consuming && !redirect;
  assign perf_stall_cycle = (state == VALID) && !pc_write && !redirect;

  ifu_perf_counters u_perf (
    .clk          (clk),
    .rst          (rst),
    .consume      (perf_consume),
    .stall        (perf_stall_cycle),
    .perf_fetched (perf_fetched),
    .perf_stall   (perf_stall)
  );
`else
  // Counters are absent in this build.
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed scenarios plus randomized
// traffic against a transaction-level model of the fetch behaviour.
module tb_if_fetch_unit;
  import if_pkg::*;

  logic        clk;
  logic        rst;
  logic        pc_write;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] instruction;
  logic [31:0] pc_out;
  logic        fetch_valid;
`ifdef IFU_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;
`endif

  if_fetch_unit_if imem ();

  if_fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .pc_write    (pc_write),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem        (imem),
    .instruction (instruction),
    .pc_out      (pc_out),
    .fetch_valid (fetch_valid)
`ifdef IFU_PERF_CNT_EN
    ,
    .perf_fetched(perf_fetched),
    .perf_stall  (perf_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: architectural PC, one outstanding-request flag, a
  // "response is stale" flag and the presented instruction.
  logic [31:0] m_pc;
  bit          m_out;
  bit          m_stale;
  bit          m_pres;
  logic [31:0] m_instr;
  int unsigned m_fetched;
  int unsigned m_stall;

  // Memory model state.
  bit          mem_pend;
  int          mem_cnt;
  logic [31:0] mem_data;
  bit          ovr_en;
  logic [31:0] ovr_data;

  // Last observed values, for directed checks against constants.
  logic        o_req;
  logic [31:0] o_addr;
  logic        o_valid;
  logic [31:0] o_instr;
  logic [31:0] o_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'd0) return 32'h0010_0093;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle: inputs just after the edge, grant once imem_req has
  // settled, outputs checked before the next edge, model stepped at the edge.
  task automatic applyStimulus(input bit pw, input bit rd, input logic [31:0] rpc,
                               input int gnt_pct, input int lat);
    bit          rv;
    bit          exp_req;
    logic [31:0] exp_addr;
    bit          gv;
    bit          g;
    pc_write    = pw;
    redirect    = rd;
    redirect_pc = rpc;
    rv = mem_pend && (mem_cnt == 0);
    imem.imem_rvalid = rv;
    imem.imem_rdata  = rv ? mem_data : $urandom;
    imem.imem_gnt    = 1'b0;
    #1;
    exp_req  = !rd && ((!m_pres && !m_out) || (m_pres && pw));
    exp_addr = (m_pres && pw) ? m_pc + 32'd4 : m_pc;
    o_req  = imem.imem_req;
    o_addr = imem.imem_addr;
    checkOutput("imem_req", 32'(o_req), 32'(exp_req));
    if (exp_req) checkOutput("imem_addr", o_addr, exp_addr);
    if (o_req) imem.imem_gnt = ($urandom_range(99) < gnt_pct);
    else       imem.imem_gnt = 1'($urandom_range(1));
    gv = imem.imem_gnt;
    #3;
    o_valid = fetch_valid;
    o_instr = instruction;
    o_pc    = pc_out;
    checkOutput("fetch_valid", 32'(o_valid), 32'(m_pres));
    checkOutput("instruction", o_instr, m_pres ? m_instr : NOP_INSN);
    checkOutput("pc_out", o_pc, m_pc);
`ifdef IFU_PERF_CNT_EN
    checkOutput("perf_fetched", perf_fetched, m_fetched);
    checkOutput("perf_stall", perf_stall, m_stall);
`endif
    g = gv && exp_req;
    @(posedge clk);
    if (rd) begin
      m_pc = rpc;
      if (m_out) m_stale = 1'b1;
      m_pres = 1'b0;
    end else if (m_pres && pw) begin
      m_pc = m_pc + 32'd4;
      m_pres = 1'b0;
      m_fetched++;
    end else if (m_pres) begin
      m_stall++;
    end
    if (m_out && rv) begin
      m_out = 1'b0;
      if (!m_stale) begin
        m_pres  = 1'b1;
        m_instr = mem_word(m_pc);
      end
      m_stale = 1'b0;
    end
    if (g) begin
      m_out   = 1'b1;
      m_stale = 1'b0;
    end
    if (rv) mem_pend = 1'b0;
    else if (mem_pend && mem_cnt > 0) mem_cnt--;
    if (o_req && gv) begin
      mem_pend = 1'b1;
      mem_cnt  = lat;
      mem_data = ovr_en ? ovr_data : mem_word(o_addr);
    end
    #1;
  endtask

  task automatic doReset(input int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) begin
      pc_write         = 1'($urandom_range(1));
      redirect         = 1'($urandom_range(1));
      redirect_pc      = $urandom;
      imem.imem_gnt    = 1'($urandom_range(1));
      imem.imem_rvalid = 1'b0;
      #1;
      checkOutput("rst imem_req", 32'(imem.imem_req), 32'd0);
      #3;
      checkOutput("rst fetch_valid", 32'(fetch_valid), 32'd0);
      checkOutput("rst instruction", instruction, NOP_INSN);
      if (i > 0) begin
        checkOutput("rst pc_out", pc_out, DEFAULT_RESET_PC);
`ifdef IFU_PERF_CNT_EN
        checkOutput("rst perf_fetched", perf_fetched, 32'd0);
        checkOutput("rst perf_stall", perf_stall, 32'd0);
`endif
      end
      @(posedge clk);
      #1;
    end
    rst       = 1'b0;
    m_pc      = DEFAULT_RESET_PC;
    m_out     = 1'b0;
    m_stale   = 1'b0;
    m_pres    = 1'b0;
    m_instr   = 32'd0;
    m_fetched = 0;
    m_stall   = 0;
    mem_pend  = 1'b0;
    mem_cnt   = 0;
    ovr_en    = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] held_instr;
    logic [31:0] held_pc;
    int          waited;
    rst              = 1'b1;
    pc_write         = 1'b0;
    redirect         = 1'b0;
    redirect_pc      = 32'd0;
    imem.imem_gnt    = 1'b0;
    imem.imem_rvalid = 1'b0;
    imem.imem_rdata  = 32'd0;
    ovr_en           = 1'b0;
    ovr_data         = 32'd0;
    @(posedge clk);
    #1;

    // Zero-wait memory, first fetch latency and next address.
    doReset(3);
    applyStimulus(1, 0, 0, 100, 0);
    checkOutput("t1 c1 req", 32'(o_req), 32'd1);
    checkOutput("t1 c1 addr", o_addr, 32'h0);
    applyStimulus(1, 0, 0, 100, 0);
    applyStimulus(1, 0, 0, 100, 0);
    checkOutput("t1 c3 valid", 32'(o_valid), 32'd1);
    checkOutput("t1 c3 instr", o_instr, 32'h0010_0093);
    checkOutput("t1 c3 pc", o_pc, 32'h0);
    checkOutput("t1 c3 next addr", o_addr, 32'h4);

    // Five stall cycles while VALID.
    doReset(2);
    applyStimulus(0, 0, 0, 100, 0);
    applyStimulus(0, 0, 0, 100, 0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 0, 0, 100, 0);
      checkOutput("t2 stall instr", o_instr, 32'h0010_0093);
      checkOutput("t2 stall pc", o_pc, 32'h0);
      checkOutput("t2 stall req", 32'(o_req), 32'd0);
    end
    applyStimulus(1, 0, 0, 100, 0);
`ifdef IFU_PERF_CNT_EN
    checkOutput("t2 perf_stall", perf_stall, 32'd5);
`endif

    // Redirect while waiting; the late DEAD_BEEF response must be dropped.
    doReset(2);
    ovr_en   = 1'b1;
    ovr_data = 32'hDEAD_BEEF;
    applyStimulus(1, 0, 0, 100, 3);
    ovr_en = 1'b0;
    applyStimulus(1, 1, 32'h0000_0100, 100, 3);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 0, 0, 100, 0);
      checkOutput("t3 killed valid", 32'(o_valid), 32'd0);
    end
    applyStimulus(1, 0, 0, 100, 0);
    checkOutput("t3 refetch req", 32'(o_req), 32'd1);
    checkOutput("t3 refetch addr", o_addr, 32'h0000_0100);
    waited = 0;
    do begin
      applyStimulus(0, 0, 0, 100, 0);
      waited++;
    end while (!o_valid && waited < 10);
    checkOutput("t3 refetch valid", 32'(o_valid), 32'd1);
    checkOutput("t3 refetch pc", o_pc, 32'h0000_0100);

    // Redirect and pc_write together at pc 8.
    doReset(2);
    for (int i = 0; i < 6; i++) applyStimulus(1, 0, 0, 100, 0);
    applyStimulus(1, 1, 32'h0000_0200, 100, 0);
    checkOutput("t4 valid", 32'(o_valid), 32'd1);
    checkOutput("t4 pc", o_pc, 32'h8);
    checkOutput("t4 req", 32'(o_req), 32'd0);
    applyStimulus(1, 0, 0, 100, 0);
    checkOutput("t4 redirect addr", o_addr, 32'h0000_0200);

    // PC wrap from the top of the address space.
    doReset(2);
    applyStimulus(1, 1, 32'hFFFF_FFFC, 100, 0);
    applyStimulus(1, 0, 0, 100, 0);
    checkOutput("t5 addr top", o_addr, 32'hFFFF_FFFC);
    applyStimulus(1, 0, 0, 100, 0);
    applyStimulus(1, 0, 0, 100, 0);
    checkOutput("t5 pc top", o_pc, 32'hFFFF_FFFC);
    checkOutput("t5 wrap addr", o_addr, 32'h0);
    applyStimulus(1, 0, 0, 100, 0);
    applyStimulus(1, 0, 0, 100, 0);
    checkOutput("t5 wrapped pc", o_pc, 32'h0);

    // Reset during WAIT; a late response after release is ignored.
    doReset(2);
    applyStimulus(1, 0, 0, 100, 5);
    applyStimulus(1, 0, 0, 100, 5);
    doReset(2);
    mem_pend = 1'b1;
    mem_cnt  = 0;
    mem_data = 32'hDEAD_BEEF;
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("t6 valid", 32'(o_valid), 32'd0);
    checkOutput("t6 addr", o_addr, DEFAULT_RESET_PC);

    // Randomized traffic across several memory/stall profiles.
    doReset(2);
    for (int ph = 0; ph < 4; ph++) begin
      int gp;
      int lm;
      int pp;
      case (ph)
        0:       begin gp = 100; lm = 0; pp = 100; end
        1:       begin gp = 50;  lm = 3; pp = 70;  end
        2:       begin gp = 30;  lm = 6; pp = 40;  end
        default: begin gp = 80;  lm = 2; pp = 90;  end
      endcase
      for (int i = 0; i < 500; i++) begin
        bit          pw;
        bit          rd;
        logic [31:0] r;
        if ($urandom_range(299) == 0) doReset($urandom_range(3, 1));
        pw = ($urandom_range(99) < pp);
        rd = ($urandom_range(99) < 8);
        r  = $urandom;
        if ($urandom_range(9) == 0) r = 32'hFFFF_FFF8 | (r & 32'h4);
        applyStimulus(pw, rd, r & ~32'h3, gp, $urandom_range(lm, 0));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
